calc_sat_stream: RTL and testbench
==================================

Name: calc_sat_stream

Overview:
Parametrised successor of the per-pixel saturation stage in the dehaze pipeline. It normalises each RGB pixel by the atmospheric light A and computes three outputs: hazy saturation S_H, dehazed-saturation estimate S_D, and the channel-sum term K. Compared with the fixed 8-bit stage it adds:
- parametrised pixel and output precision;
- valid/ready backpressure with a full-pipeline stall;
- frame-synchronous shadowing of A;
- SOF/EOL sideband passthrough.
It sits between the atmospheric-light estimator and the transmission/recovery stage.

Parameters:
PIX_W, 8, bits per colour channel (4..12)
FRAC_W, 12, fractional bits of S_H/S_D outputs, Q0.FRAC_W (8..16)
NRM_FRAC, 8, fractional bits of normalised channel n_c; n_c is Q2.NRM_FRAC, NRM_FRAC+2 bits
LAT, 6, fixed pipeline latency in enabled cycles (>=4)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_r, in_g, in_b  in  PIX_W each  pixel channels
in_sof  in  1  first pixel of frame
in_eol  in  1  last pixel of line
in_valid  in  1  pixel qualifier
in_ready  out  1  pixel accepted when in_valid&&in_ready
a_r, a_g, a_b  in  PIX_W each  atmospheric light
a_valid  in  1  one-cycle strobe loading a_* into the pending register
out_s_h  out  FRAC_W  S_H, Q0.FRAC_W
out_s_d  out  FRAC_W  S_D, Q0.FRAC_W
out_k  out  NRM_FRAC+4  K, Q4.NRM_FRAC
out_sof, out_eol  out  1  delayed sideband
out_valid  out  1  output qualifier
out_ready  in  1  downstream ready

Behaviour:
- Reset:
  - All outputs 0; in_ready=1 at first cycle after reset.
  - a_pend and a_cur = all-ones (A=2^PIX_W-1 per channel); a_seen=0.
  - Reset mid-operation discards all in-flight pixels; no partial output.
- Pipeline enable: en = out_ready || !out_valid; in_ready = en.
  - When en=0, every stage, valid bit and sideband bit holds.
  - Output data is stable while out_valid && !out_ready.
- Latency:
  - An accepted pixel appears at the output after exactly LAT enabled cycles; LAT clock cycles when never stalled.
  - Throughput is 1 pixel/cycle; bubbles propagate as valid=0.
- A handling:
  - a_valid writes a_pend (last strobe wins).
  - a_cur <= a_pend when a pixel with in_sof=1 is accepted; that pixel already uses the new value.
  - Until the first a_valid after reset, a_cur follows a_pend continuously (a_seen=0). From the first a_valid on, a_seen=1 and a_cur updates only on SOF.
  - a_valid in the same cycle as an SOF accept: the new a_* value is used for that SOF pixel.
  - A channel equal to 0 is treated as 1.
- Arithmetic (exact, integer floor; bench model uses the same):
  - n_c = min(floor(c*2^NRM_FRAC / A_c), 2^(NRM_FRAC+2)-1), for c in {r,g,b}.
  - K = n_r+n_g+n_b; if K==0 then K=1.
  - m = min(n_r,n_g,n_b); D = K-3m (always >=0).
  - S_H = min(floor(D*2^FRAC_W / K), 2^FRAC_W-1).
  - S_D = floor(S_H*(2^(FRAC_W+1)-1-S_H) / 2^FRAC_W), saturated to 2^FRAC_W-1.
  - out_k = K.
  - Dividers may be pipelined or use a reciprocal table, but must be bit-exact to the formulas for all inputs.
- Sideband: in_sof/in_eol travel with their pixel unchanged.
- Simultaneous in-accept and out-accept while full: both complete with no loss or duplication.

Test Plan:
1. A=(200,200,200) loaded, pixel (100,100,100) with SOF, out_ready=1 → after 6 cycles out_valid=1, n=128, out_k=384, out_s_h=0, out_s_d=0, out_sof=1.
2. A=(255,255,255), pixels (200,100,0) then (200,100,100) back-to-back → out_k=300, S_H=4095, S_D=4095; next cycle out_k=400, S_H=1024, S_D=1791.
3. Black pixel (0,0,0), A=255 → K forced 1, out_k=1, S_H=4095, S_D=4095; A=(0,0,0), pixel (5,5,5) → n clipped 1023, out_k=3069, S_H=0.
4. Stream of 20 pixels, out_ready toggled pseudo-randomly → in_ready==out_ready||!out_valid every cycle; output order, count and values match model; data stable during stall.
5. Frame 1 with A=255; a_valid A=128 mid-frame → the rest of frame 1 still uses 255; frame 2 SOF pixel (64,64,64) → n=128, out_k=384.
6. Assert rst_n low with 4 pixels in flight → out_valid=0 and outputs 0 immediately; after release, a fresh pixel emerges after 6 cycles with no stale output.

Source files
------------

// File: rtl/calc_sat_stream_if.sv
// Stream bundle for calc_sat_stream: pixel input, atmospheric-light load, and result output.
interface calc_sat_stream_if #(
    parameter int PIX_W    = 8,
    parameter int FRAC_W   = 12,
    parameter int NRM_FRAC = 8
);
    logic [PIX_W-1:0]    in_r;
    logic [PIX_W-1:0]    in_g;
    logic [PIX_W-1:0]    in_b;
    logic                in_sof;
    logic                in_eol;
    logic                in_valid;
    logic                in_ready;

    logic [PIX_W-1:0]    a_r;
    logic [PIX_W-1:0]    a_g;
    logic [PIX_W-1:0]    a_b;
    logic                a_valid;

    logic [FRAC_W-1:0]   out_s_h;
    logic [FRAC_W-1:0]   out_s_d;
    logic [NRM_FRAC+3:0] out_k;
    logic                out_sof;
    logic                out_eol;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output in_r, in_g, in_b, in_sof, in_eol, in_valid,
        input  in_ready,
        output a_r, a_g, a_b, a_valid,
        input  out_s_h, out_s_d, out_k, out_sof, out_eol, out_valid,
        output out_ready
    );

    modport slave (
        input  in_r, in_g, in_b, in_sof, in_eol, in_valid,
        output in_ready,
        input  a_r, a_g, a_b, a_valid,
        output out_s_h, out_s_d, out_k, out_sof, out_eol, out_valid,
        input  out_ready
    );
endinterface

// File: rtl/calc_sat_stream.sv
// Per-pixel haze saturation: normalise RGB by atmospheric light A, emit S_H, S_D and channel sum K.
// Latency: LAT enabled cycles from accept to out_valid; one pixel per cycle.
// Backpressure: whole pipeline stalls when out_valid && !out_ready; in_ready mirrors the stage enable.
module calc_sat_stream #(
    parameter int PIX_W    = 8,
    parameter int FRAC_W   = 12,
    parameter int NRM_FRAC = 8,
    parameter int LAT      = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    calc_sat_stream_if.slave io
);
    localparam int NW = NRM_FRAC + 2;
    localparam int KW = NRM_FRAC + 4;
    localparam int QW = PIX_W + NRM_FRAC;
    localparam int SW = KW + FRAC_W;
    localparam int PW = 2 * FRAC_W + 1;

    localparam logic [NW-1:0]     N_MAX = '1;
    localparam logic [FRAC_W-1:0] F_MAX = '1;

    typedef logic [PIX_W-1:0] pix_t;

    typedef struct packed {
        pix_t r;
        pix_t g;
        pix_t b;
    } rgb_t;

    typedef struct packed {
        logic vld;
        logic sof;
        logic eol;
    } sb_t;

    typedef struct packed {
        sb_t               sb;
        logic [FRAC_W-1:0] s_h;
        logic [FRAC_W-1:0] s_d;
        logic [KW-1:0]     k;
    } res_t;

    // Normalised channel, Q2.NRM_FRAC, with A=0 treated as 1 and the result clipped.
    function automatic logic [NW-1:0] norm(input pix_t c, input pix_t a);
        logic [QW-1:0] num;
        logic [QW-1:0] den;
        logic [QW-1:0] q;
        num = {c, {NRM_FRAC{1'b0}}};
        den = (a == '0) ? QW'(1) : QW'(a);
        q   = num / den;
        return (q > QW'(N_MAX)) ? N_MAX : q[NW-1:0];
    endfunction

    // Atmospheric light shadowing
    rgb_t a_pend;
    rgb_t a_cur;
    logic a_seen;
    rgb_t a_in;
    rgb_t a_pend_nxt;
    rgb_t a_use;

    // Pipeline control
    logic en;
    logic sof_acc;
    logic cur_load;

    // Stage registers
    sb_t           sb1;
    rgb_t          pix1;
    rgb_t          a1;
    sb_t           sb2;
    logic [NW-1:0] n_r2;
    logic [NW-1:0] n_g2;
    logic [NW-1:0] n_b2;
    sb_t           sb3;
    logic [KW-1:0] k3;
    logic [KW-1:0] d3;
    res_t          res_q [4:LAT];

    // Stage combinational results
    logic [KW-1:0]     k_sum;
    logic [NW-1:0]     n_min;
    logic [KW-1:0]     d_nxt;
    logic [SW-1:0]     sh_q;
    logic [SW-1:0]     sh_den;
    logic [FRAC_W-1:0] sh;
    logic [FRAC_W:0]   comp;
    logic [PW-1:0]     prod;
    logic [PW-1:0]     sd_q;
    logic [FRAC_W-1:0] sd;
    res_t              res_d;

    assign en       = io.out_ready || !res_q[LAT].sb.vld;
    assign sof_acc  = io.in_valid && en && io.in_sof;
    // Before the first strobe A tracks the pending value; afterwards it only moves on SOF.
    assign cur_load = sof_acc || !a_seen;

    assign a_in       = {io.a_r, io.a_g, io.a_b};
    assign a_pend_nxt = io.a_valid ? a_in : a_pend;
    assign a_use      = cur_load ? a_pend_nxt : a_cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_pend <= '1;
            a_cur  <= '1;
            a_seen <= 1'b0;
        end else begin
            a_pend <= a_pend_nxt;
            if (cur_load) begin
                a_cur <= a_pend_nxt;
            end
            if (io.a_valid) begin
                a_seen <= 1'b1;
            end
        end
    end

    // Stage 3: channel sum, minimum and spread
    always_comb begin
        k_sum = KW'(n_r2) + KW'(n_g2) + KW'(n_b2);
        if (k_sum == '0) begin
            k_sum = KW'(1);
        end
        n_min = n_r2;
        if (n_g2 < n_min) begin
            n_min = n_g2;
        end
        if (n_b2 < n_min) begin
            n_min = n_b2;
        end
        d_nxt = k_sum - (KW'(n_min) + KW'(n_min) + KW'(n_min));
    end

    // Stage 4: S_H = D/K and S_D = S_H*(2-S_H), both saturated to Q0.FRAC_W
    always_comb begin
        sh_den = (k3 == '0) ? SW'(1) : SW'(k3);
        sh_q   = {d3, {FRAC_W{1'b0}}} / sh_den;
        sh     = (sh_q > SW'(F_MAX)) ? F_MAX : sh_q[FRAC_W-1:0];
        comp   = {1'b1, {FRAC_W{1'b1}}} - {1'b0, sh};
        prod   = PW'(sh) * PW'(comp);
        sd_q   = prod >> FRAC_W;
        sd     = (sd_q > PW'(F_MAX)) ? F_MAX : sd_q[FRAC_W-1:0];
        res_d  = '{sb: sb3, s_h: sh, s_d: sd, k: k3};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb1  <= '0;
            pix1 <= '0;
            a1   <= '1;
            sb2  <= '0;
            n_r2 <= '0;
            n_g2 <= '0;
            n_b2 <= '0;
            sb3  <= '0;
            k3   <= KW'(1);
            d3   <= '0;
            for (int i = 4; i <= LAT; i++) begin
                res_q[i] <= '0;
            end
        end else if (en) begin
            sb1  <= '{vld: io.in_valid, sof: io.in_sof, eol: io.in_eol};
            pix1 <= {io.in_r, io.in_g, io.in_b};
            a1   <= a_use;
            sb2  <= sb1;
            n_r2 <= norm(pix1.r, a1.r);
            n_g2 <= norm(pix1.g, a1.g);
            n_b2 <= norm(pix1.b, a1.b);
            sb3  <= sb2;
            k3   <= k_sum;
            d3   <= d_nxt;
            res_q[4] <= res_d;
            for (int i = 5; i <= LAT; i++) begin
                res_q[i] <= res_q[i-1];
            end
        end
    end

    assign io.in_ready  = en;
    assign io.out_valid = res_q[LAT].sb.vld;
    assign io.out_sof   = res_q[LAT].sb.sof;
    assign io.out_eol   = res_q[LAT].sb.eol;
    assign io.out_s_h   = res_q[LAT].s_h;
    assign io.out_s_d   = res_q[LAT].s_d;
    assign io.out_k     = res_q[LAT].k;
endmodule

// File: tb/tb_calc_sat_stream.sv
// Bench for calc_sat_stream: hand-computed vector table, corner sequences and a randomized scoreboard run.
module tb_calc_sat_stream;
    localparam int PIX_W    = 8;
    localparam int FRAC_W   = 12;
    localparam int NRM_FRAC = 8;
    localparam int LAT      = 6;
    localparam int AMAX     = (1 << PIX_W) - 1;
    localparam int N_MAX    = (1 << (NRM_FRAC + 2)) - 1;
    localparam int F_MAX    = (1 << FRAC_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    calc_sat_stream_if #(.PIX_W(PIX_W), .FRAC_W(FRAC_W), .NRM_FRAC(NRM_FRAC)) bus ();

    calc_sat_stream #(.PIX_W(PIX_W), .FRAC_W(FRAC_W), .NRM_FRAC(NRM_FRAC), .LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int sh;
        int sd;
        int k;
        bit sof;
        bit eol;
    } exp_t;

    // Reference arithmetic straight from the formulas
    function automatic int nrm(input int c, input int a);
        int q;
        int d;
        d = (a == 0) ? 1 : a;
        q = (c * (1 << NRM_FRAC)) / d;
        return (q > N_MAX) ? N_MAX : q;
    endfunction

    function automatic exp_t model(input int r, input int g, input int b,
                                   input int ar, input int ag, input int ab,
                                   input bit sof, input bit eol);
        exp_t   e;
        int     nr, ng, nb, k, m, d;
        longint sd;
        nr = nrm(r, ar);
        ng = nrm(g, ag);
        nb = nrm(b, ab);
        k  = nr + ng + nb;
        if (k == 0) k = 1;
        m  = nr;
        if (ng < m) m = ng;
        if (nb < m) m = nb;
        d  = k - 3 * m;
        e.sh = (d * (1 << FRAC_W)) / k;
        if (e.sh > F_MAX) e.sh = F_MAX;
        sd = (longint'(e.sh) * longint'((1 << (FRAC_W + 1)) - 1 - e.sh)) / (1 << FRAC_W);
        e.sd  = (sd > F_MAX) ? F_MAX : int'(sd);
        e.k   = k;
        e.sof = sof;
        e.eol = eol;
        return e;
    endfunction

    // Scoreboard monitor with its own view of the A shadowing rules
    exp_t sb_q[$];
    exp_t exp_e;
    int   pend [3];
    int   cur  [3];
    int   pn   [3];
    int   ain  [3];
    bit   seen;
    bit   m_acc;
    bit   m_ld;
    bit   prev_stall;
    int   p_sh, p_sd, p_k;
    bit   p_sof, p_eol;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            for (int c = 0; c < 3; c++) begin
                pend[c] = AMAX;
                cur[c]  = AMAX;
            end
            seen       = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", longint'(bus.out_valid), 1);
                check("stall_sh",    longint'(bus.out_s_h), longint'(p_sh));
                check("stall_sd",    longint'(bus.out_s_d), longint'(p_sd));
                check("stall_k",     longint'(bus.out_k),   longint'(p_k));
                check("stall_sof",   longint'(bus.out_sof), longint'(p_sof));
                check("stall_eol",   longint'(bus.out_eol), longint'(p_eol));
            end
            check("in_ready_rule", longint'(bus.in_ready), longint'(bus.out_ready || !bus.out_valid));
            if (bus.out_valid && bus.out_ready) begin
                check("sb_nonempty", longint'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    exp_e = sb_q.pop_front();
                    check("sb_k",   longint'(bus.out_k),   longint'(exp_e.k));
                    check("sb_sh",  longint'(bus.out_s_h), longint'(exp_e.sh));
                    check("sb_sd",  longint'(bus.out_s_d), longint'(exp_e.sd));
                    check("sb_sof", longint'(bus.out_sof), longint'(exp_e.sof));
                    check("sb_eol", longint'(bus.out_eol), longint'(exp_e.eol));
                end
            end
            ain[0] = int'(bus.a_r);
            ain[1] = int'(bus.a_g);
            ain[2] = int'(bus.a_b);
            for (int c = 0; c < 3; c++) begin
                pn[c] = bus.a_valid ? ain[c] : pend[c];
            end
            m_acc = bus.in_valid && bus.in_ready;
            m_ld  = (m_acc && bus.in_sof) || !seen;
            if (m_acc) begin
                if (m_ld) sb_q.push_back(model(int'(bus.in_r), int'(bus.in_g), int'(bus.in_b),
                                               pn[0], pn[1], pn[2], bus.in_sof, bus.in_eol));
                else      sb_q.push_back(model(int'(bus.in_r), int'(bus.in_g), int'(bus.in_b),
                                               cur[0], cur[1], cur[2], bus.in_sof, bus.in_eol));
            end
            for (int c = 0; c < 3; c++) begin
                if (m_ld) cur[c] = pn[c];
                pend[c] = pn[c];
            end
            if (bus.a_valid) seen = 1'b1;
            prev_stall = bus.out_valid && !bus.out_ready;
            p_sh  = int'(bus.out_s_h);
            p_sd  = int'(bus.out_s_d);
            p_k   = int'(bus.out_k);
            p_sof = bus.out_sof;
            p_eol = bus.out_eol;
        end
    end

    typedef struct {
        bit load;
        bit same;
        int ar, ag, ab;
        int r, g, b;
        bit sof, eol;
        int k, sh, sd;
    } vec_t;

    vec_t tbl [12];

    task automatic set_a(input int ar, input int ag, input int ab);
        bus.a_r = PIX_W'(ar);
        bus.a_g = PIX_W'(ag);
        bus.a_b = PIX_W'(ab);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        if (v.load && !v.same) begin
            bus.a_valid = 1'b1;
            set_a(v.ar, v.ag, v.ab);
            @(posedge clk); #1;
            bus.a_valid = 1'b0;
        end
        bus.in_r     = PIX_W'(v.r);
        bus.in_g     = PIX_W'(v.g);
        bus.in_b     = PIX_W'(v.b);
        bus.in_sof   = v.sof;
        bus.in_eol   = v.eol;
        bus.in_valid = 1'b1;
        if (v.load && v.same) begin
            bus.a_valid = 1'b1;
            set_a(v.ar, v.ag, v.ab);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a_valid  = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_eol   = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("v%0d_latency", idx), longint'(lat), LAT);
        check($sformatf("v%0d_k", idx),   longint'(bus.out_k),   longint'(v.k));
        check($sformatf("v%0d_sh", idx),  longint'(bus.out_s_h), longint'(v.sh));
        check($sformatf("v%0d_sd", idx),  longint'(bus.out_s_d), longint'(v.sd));
        check($sformatf("v%0d_sof", idx), longint'(bus.out_sof), longint'(v.sof));
        check($sformatf("v%0d_eol", idx), longint'(bus.out_eol), longint'(v.eol));
        @(posedge clk); #1;
    endtask

    bit drv_acc;
    int lat2;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //          load same  ar   ag   ab    r    g    b  sof eol     k    sh    sd
        tbl[0]  = '{1, 0, 200, 200, 200, 100, 100, 100, 1, 0,  384,    0,    0};
        tbl[1]  = '{1, 0, 255, 255, 255, 200, 100,   0, 1, 0,  300, 4095, 4095};
        tbl[2]  = '{0, 0,   0,   0,   0, 200, 100, 100, 0, 1,  400, 1024, 1791};
        tbl[3]  = '{1, 0, 255, 255, 255,   0,   0,   0, 1, 0,    1, 4095, 4095};
        tbl[4]  = '{1, 0,   0,   0,   0,   5,   5,   5, 1, 0, 3069,    0,    0};
        tbl[5]  = '{1, 0, 255, 255, 255,  64,  64,  64, 1, 0,  192,    0,    0};
        tbl[6]  = '{1, 0, 128, 128, 128,  64,  64,  64, 0, 1,  192,    0,    0};
        tbl[7]  = '{0, 0,   0,   0,   0,  64,  64,  64, 1, 0,  384,    0,    0};
        tbl[8]  = '{1, 0, 255, 255, 255, 255, 128,  64, 1, 0,  448, 2340, 3342};
        tbl[9]  = '{1, 0, 100, 200,  50,  50,  50,  50, 1, 1,  448, 2340, 3342};
        tbl[10] = '{1, 1, 128, 128, 128,  64,  64,  64, 1, 0,  384,    0,    0};
        tbl[11] = '{0, 0,   0,   0,   0, 100, 100, 100, 1, 1,  300,    0,    0};

        bus.in_r = '0; bus.in_g = '0; bus.in_b = '0;
        bus.in_sof = 1'b0; bus.in_eol = 1'b0; bus.in_valid = 1'b0;
        set_a(0, 0, 0);
        bus.a_valid = 1'b0;
        bus.out_ready = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", longint'(bus.out_valid), 0);
        check("rst_out_k",     longint'(bus.out_k),     0);
        check("rst_out_sh",    longint'(bus.out_s_h),   0);
        check("rst_out_sd",    longint'(bus.out_s_d),   0);
        check("rst_out_sof",   longint'(bus.out_sof),   0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready",  longint'(bus.in_ready),  1);

        for (int i = 0; i < 11; i++) begin
            run_vec(tbl[i], i);
        end

        // Back-to-back pair sharing one A load on the SOF pixel
        bus.a_valid = 1'b1;
        set_a(255, 255, 255);
        bus.in_r = 8'd200; bus.in_g = 8'd100; bus.in_b = 8'd0;
        bus.in_sof = 1'b1; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.a_valid = 1'b0;
        bus.in_sof = 1'b0;
        bus.in_b = 8'd100;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat2 = 2;
        while (!bus.out_valid && lat2 < 40) begin
            @(posedge clk); #1;
            lat2++;
        end
        check("b2b_latency", longint'(lat2), LAT);
        check("b2b0_k",  longint'(bus.out_k),   300);
        check("b2b0_sh", longint'(bus.out_s_h), 4095);
        check("b2b0_sd", longint'(bus.out_s_d), 4095);
        @(posedge clk); #1;
        check("b2b1_valid", longint'(bus.out_valid), 1);
        check("b2b1_k",  longint'(bus.out_k),   400);
        check("b2b1_sh", longint'(bus.out_s_h), 1024);
        check("b2b1_sd", longint'(bus.out_s_d), 1791);
        @(posedge clk); #1;

        // Randomized stream with random backpressure and A reloads
        drv_acc = 1'b1;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (!bus.in_valid || drv_acc) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_r     = PIX_W'($urandom_range(0, AMAX));
                bus.in_g     = PIX_W'($urandom_range(0, AMAX));
                bus.in_b     = PIX_W'($urandom_range(0, AMAX));
                bus.in_sof   = ($urandom_range(0, 7) == 0);
                bus.in_eol   = ($urandom_range(0, 5) == 0);
            end
            bus.a_valid = ($urandom_range(0, 9) == 0);
            if (bus.a_valid) begin
                set_a(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, AMAX),
                      $urandom_range(0, AMAX), $urandom_range(0, AMAX));
            end
            bus.out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            drv_acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.a_valid   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (LAT + 4) @(posedge clk);
        #1;
        check("drain_empty", longint'(sb_q.size()), 0);

        // Reset with pixels in flight
        bus.in_sof = 1'b0;
        bus.in_eol = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_r = PIX_W'(30 + i); bus.in_g = PIX_W'(90); bus.in_b = PIX_W'(200 - i);
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", longint'(bus.out_valid), 0);
        check("midrst_k",     longint'(bus.out_k),     0);
        check("midrst_sh",    longint'(bus.out_s_h),   0);
        check("midrst_sd",    longint'(bus.out_s_d),   0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("midrst_in_ready", longint'(bus.in_ready), 1);
        @(posedge clk); #1;
        run_vec(tbl[11], 11);
        repeat (2) @(posedge clk);
        #1;
        check("final_empty", longint'(sb_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
